status_flag_unit: RTL and testbench

- Owns the architectural NZCV status register and sits directly upstream of the condition-check stage.
- Supplies the flag vector that the ID-stage condition check evaluates.
- Tracks whether the instruction in EXE will write the flags (S-bit), and resolves the resulting read-after-write flag hazard by forwarding or by a one-cycle ID stall.
- Keeps a saturating counter of flag-hazard stalls for performance debug.

---
 rtl/status_flag_unit_pkg.sv | 21 ++
 rtl/status_flag_unit_reg.sv | 20 ++
 rtl/status_flag_unit.sv | 81 ++++++++
 tb/tb_status_flag_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/status_flag_unit_pkg.sv
// Shared NZCV definitions used by the status flag unit and the condition-check stage.
package status_flag_unit_pkg;

    localparam int unsigned NZCV_W = 4;

    localparam int unsigned FLG_N = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef logic [NZCV_W-1:0] nzcv_t;

    // Conditions other than AL/NV must read the flags.
    function automatic logic cond_reads_flags(input logic [3:0] cond);
        return (cond != COND_AL) && (cond != COND_NV);
    endfunction

endpackage

// File: rtl/status_flag_unit_reg.sv
// 4-bit NZCV holding register with async active-high reset and write enable.
module status_reg
    import status_flag_unit_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  we,
    input  nzcv_t d,
    output nzcv_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/status_flag_unit.sv
// Architectural NZCV register with EXE flag-write tracking and RAW hazard
// resolution (forwarding or one-cycle ID stall), plus a saturating stall counter.
module status_flag_unit
    import status_flag_unit_pkg::*;
#(
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [3:0]       id_cond,
    input  logic             id_s,
    input  nzcv_t            exe_alu_nzcv,
    output nzcv_t            sr_nzcv,
    output nzcv_t            cond_nzcv,
    output logic             flag_stall,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic  exe_valid_q;
    logic  exe_s_q;
    logic  needs_flags;
    logic  hazard;
    logic  sr_we;
    nzcv_t sr_q;

    assign needs_flags = id_valid & cond_reads_flags(id_cond);
    assign hazard      = needs_flags & exe_valid_q & exe_s_q;
    assign sr_we       = ~freeze & exe_valid_q & exe_s_q;

    // EXE-stage tracker: a stall or flush inserts a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_valid_q <= 1'b0;
            exe_s_q     <= 1'b0;
        end else if (!freeze) begin
            if (flush || flag_stall) begin
                exe_valid_q <= 1'b0;
                exe_s_q     <= 1'b0;
            end else begin
                exe_valid_q <= id_valid;
                exe_s_q     <= id_valid & id_s;
            end
        end
    end

    status_reg u_sr (
        .clk (clk),
        .rst (rst),
        .we  (sr_we),
        .d   (exe_alu_nzcv),
        .q   (sr_q)
    );

    assign sr_nzcv = sr_q;

    generate
        if (FWD_EN) begin : g_fwd
            assign cond_nzcv  = hazard ? exe_alu_nzcv : sr_q;
            assign flag_stall = 1'b0;
        end else begin : g_stall
            // Bubble and SR write land on the same edge, so one stall suffices.
            assign cond_nzcv  = sr_q;
            assign flag_stall = hazard & ~flush;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (flag_stall && !freeze && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_status_flag_unit.sv
// Self-checking bench: forwarding, stalling and 2-bit-counter instances driven
// by shared stimulus and compared each cycle against a behavioural model.
module tb_status_flag_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       freeze = 1'b0;
    logic       flush = 1'b0;
    logic       id_valid = 1'b0;
    logic [3:0] id_cond = 4'b1110;
    logic       id_s = 1'b0;
    logic [3:0] alu = 4'b0000;

    logic [3:0]  sr_f, cond_f, sr_s, cond_s, sr_t, cond_t;
    logic        st_f, st_s, st_t;
    logic [15:0] cnt_f, cnt_s;
    logic [1:0]  cnt_t;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    status_flag_unit #(.FWD_EN(1'b1), .CNT_W(16)) u_fwd (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
        .id_cond(id_cond), .id_s(id_s), .exe_alu_nzcv(alu), .sr_nzcv(sr_f),
        .cond_nzcv(cond_f), .flag_stall(st_f), .stall_cnt(cnt_f));

    status_flag_unit #(.FWD_EN(1'b0), .CNT_W(16)) u_stl (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
        .id_cond(id_cond), .id_s(id_s), .exe_alu_nzcv(alu), .sr_nzcv(sr_s),
        .cond_nzcv(cond_s), .flag_stall(st_s), .stall_cnt(cnt_s));

    status_flag_unit #(.FWD_EN(1'b0), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
        .id_cond(id_cond), .id_s(id_s), .exe_alu_nzcv(alu), .sr_nzcv(sr_t),
        .cond_nzcv(cond_t), .flag_stall(st_t), .stall_cnt(cnt_t));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per instance, whether a flag-setting instruction sits in EXE,
    // the architectural flags, and the stall count.
    bit m_fwd  [3] = '{1'b1, 1'b0, 1'b0};
    int m_cmax [3] = '{65535, 65535, 3};
    bit       m_sin [3];
    bit [3:0] m_sr  [3];
    int       m_cnt [3];

    function automatic bit m_hazard(input int i);
        return id_valid && id_cond != 4'd14 && id_cond != 4'd15 && m_sin[i];
    endfunction

    function automatic bit m_stall(input int i);
        return !m_fwd[i] && m_hazard(i) && !flush;
    endfunction

    function automatic int m_cond(input int i);
        return (m_fwd[i] && m_hazard(i)) ? int'(alu) : int'(m_sr[i]);
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_sin[i] = 1'b0;
                m_sr[i]  = 4'd0;
                m_cnt[i] = 0;
            end else if (!freeze) begin
                if (m_sin[i]) m_sr[i] = alu;
                if (m_stall(i) && m_cnt[i] < m_cmax[i]) m_cnt[i]++;
                m_sin[i] = (flush || m_stall(i)) ? 1'b0 : (id_valid && id_s);
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        #1;
        chk("fwd.cond", int'(cond_f), m_cond(0));
        chk("fwd.stall", int'(st_f), int'(m_stall(0)));
        chk("fwd.sr", int'(sr_f), int'(m_sr[0]));
        chk("fwd.cnt", int'(cnt_f), m_cnt[0]);
        chk("stl.cond", int'(cond_s), m_cond(1));
        chk("stl.stall", int'(st_s), int'(m_stall(1)));
        chk("stl.sr", int'(sr_s), int'(m_sr[1]));
        chk("stl.cnt", int'(cnt_s), m_cnt[1]);
        chk("sat.cond", int'(cond_t), m_cond(2));
        chk("sat.stall", int'(st_t), int'(m_stall(2)));
        chk("sat.sr", int'(sr_t), int'(m_sr[2]));
        chk("sat.cnt", int'(cnt_t), m_cnt[2]);
    end

    task automatic set_in(input bit v, input bit s, input logic [3:0] c,
                          input bit fl, input bit fr, input logic [3:0] a);
        @(negedge clk);
        id_valid = v;
        id_s     = s;
        id_cond  = c;
        flush    = fl;
        freeze   = fr;
        alu      = a;
        #2;
    endtask

    localparam logic [3:0] AL = 4'b1110;
    localparam logic [3:0] NV = 4'b1111;
    localparam logic [3:0] EQ = 4'b0000;

    int sat_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst.sr", int'(sr_s), 0);
        chk("rst.stall", int'(st_s), 0);
        chk("rst.cnt", int'(cnt_s), 0);
        chk("rst.cond", int'(cond_f), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Saturation on the 2-bit counter instance.
        for (int k = 0; k < 5; k++) begin
            set_in(1, 1, AL, 0, 0, 4'b1001);
            set_in(1, 0, EQ, 0, 0, 4'b1001);
            chk("sat.stall_lit", int'(st_t), 1);
            set_in(1, 0, EQ, 0, 0, 4'b1001);
            chk("sat.cnt_lit", int'(cnt_t), sat_exp[k]);
        end

        // Reset asserted mid-cycle during a hazard stall.
        set_in(1, 1, AL, 0, 0, 4'b1001);
        set_in(1, 0, EQ, 0, 0, 4'b1001);
        chk("pre_rst.stall", int'(st_s), 1);
        chk("pre_rst.sr", int'(sr_s), 9);
        #1 rst = 1'b1;
        #1;
        chk("mrst.sr", int'(sr_s), 0);
        chk("mrst.stall", int'(st_s), 0);
        chk("mrst.cnt", int'(cnt_s), 0);
        chk("mrst.satcnt", int'(cnt_t), 0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("post_rst.stall", int'(st_s), 0);

        // Forwarding vs stall on S-instr followed by EQ.
        set_in(1, 1, AL, 0, 0, 4'b0000);
        set_in(1, 0, EQ, 0, 0, 4'b0100);
        chk("fwd1.cond", int'(cond_f), 4);
        chk("fwd1.stall", int'(st_f), 0);
        chk("stl1.stall", int'(st_s), 1);
        chk("stl1.cond", int'(cond_s), 0);
        set_in(1, 0, EQ, 0, 0, 4'b0000);
        chk("fwd2.sr", int'(sr_f), 4);
        chk("stl2.stall", int'(st_s), 0);
        chk("stl2.cond", int'(cond_s), 4);
        chk("stl2.cnt", int'(cnt_s), 1);

        // AL / NV exemption.
        set_in(1, 1, AL, 0, 0, 4'b0000);
        set_in(1, 1, AL, 0, 0, 4'b1010);
        chk("al.stall", int'(st_s), 0);
        chk("al.cond", int'(cond_f), 4);
        set_in(1, 0, NV, 0, 0, 4'b1001);
        chk("nv.stall", int'(st_s), 0);
        chk("nv.cond", int'(cond_f), 10);

        // Flush beats stall; flushed instruction never reaches EXE.
        set_in(1, 1, AL, 0, 0, 4'b0000);
        set_in(1, 0, EQ, 1, 0, 4'b0011);
        chk("flush.stall", int'(st_s), 0);
        set_in(1, 0, EQ, 0, 0, 4'b0000);
        chk("flush.next_stall", int'(st_s), 0);
        chk("flush.sr", int'(sr_s), 3);

        // Freeze during a hazard.
        set_in(1, 1, AL, 0, 0, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            set_in(1, 0, EQ, 0, 1, 4'b0110);
            chk("frz.stall", int'(st_s), 1);
            chk("frz.sr", int'(sr_s), 3);
            chk("frz.cnt", int'(cnt_s), 1);
        end
        set_in(1, 0, EQ, 0, 0, 4'b0110);
        chk("unfrz.stall", int'(st_s), 1);
        set_in(1, 0, EQ, 0, 0, 4'b0000);
        chk("unfrz.next_stall", int'(st_s), 0);
        chk("unfrz.cnt", int'(cnt_s), 2);
        chk("unfrz.sr", int'(sr_s), 6);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            set_in(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0),
                   4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 7) == 0), 4'($urandom));
        end

        @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
